// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and opcode helpers for the sequential ALU
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOTA  = 4'd5,
      OP_PASSB = 4'd6,
      OP_SHL   = 4'd7,
      OP_SHR   = 4'd8,
      OP_ASR   = 4'd9,
      OP_ROL   = 4'd10,
      OP_ROR   = 4'd11,
      OP_RCL   = 4'd12,
      OP_RCR   = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op >= OP_SHL) && (op <= OP_RCR);
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - one-bit shift/rotate of {carry, value} selected by opcode
module alu_shift_step
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] val_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] val_o,
   output logic             c_o
);

   always_comb begin
      val_o = val_i;
      c_o   = c_i;
      case (op)
         OP_SHL: begin val_o = {val_i[WIDTH-2:0], 1'b0};         c_o = val_i[WIDTH-1]; end
         OP_SHR: begin val_o = {1'b0, val_i[WIDTH-1:1]};         c_o = val_i[0];       end
         OP_ASR: begin val_o = {val_i[WIDTH-1], val_i[WIDTH-1:1]}; c_o = val_i[0];     end
         OP_ROL: begin val_o = {val_i[WIDTH-2:0], val_i[WIDTH-1]}; c_o = val_i[WIDTH-1]; end
         OP_ROR: begin val_o = {val_i[0], val_i[WIDTH-1:1]};     c_o = val_i[0];       end
         OP_RCL: begin val_o = {val_i[WIDTH-2:0], c_i};          c_o = val_i[WIDTH-1]; end
         OP_RCR: begin val_o = {c_i, val_i[WIDTH-1:1]};          c_o = val_i[0];       end
         default: begin val_o = val_i; c_o = c_i; end
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with registered result/flags, serial shifts and start/busy/done handshake
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clock,
   input  logic             notReset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             csel,
   input  logic             ucin,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             notOE,
   output wire  [WIDTH-1:0] y,
   output logic             cout,
   output logic             zout,
   output logic             nout,
   output logic             vout
);

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_q, c_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             v_q, v_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   op_e              op_q, op_d;
   logic             cin_q, cin_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] wr_q, wr_d;
   logic             wc_q, wc_d;
   logic             wv_q, wv_d;
   logic             keep_q, keep_d;

   logic [WIDTH-1:0] bb;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] step_val;
   logic             step_c;

   alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .op    (op_q),
      .val_i (wr_q),
      .c_i   (wc_q),
      .val_o (step_val),
      .c_o   (step_c)
   );

   always_comb begin
      bb  = (op_q == OP_SUB) ? ~b_q : b_q;
      sum = {1'b0, a_q} + {1'b0, bb} + {{WIDTH{1'b0}}, cin_q};
   end

   // wr/wc/wv stage the outcome; architectural flags only move in ST_DONE
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      c_d      = c_q;
      z_d      = z_q;
      n_d      = n_q;
      v_d      = v_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cin_d    = cin_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      wc_d     = wc_q;
      wv_d     = wv_q;
      keep_d   = keep_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               a_d    = a;
               b_d    = b;
               op_d   = op_e'(op);
               cin_d  = csel ? c_q : ucin;
               cnt_d  = b[SHW-1:0];
               wr_d   = a;
               wc_d   = c_q;
               wv_d   = 1'b0;
               keep_d = 1'b0;
               if (is_shift(op) && (b[SHW-1:0] != '0))
                  state_d = ST_SHIFT;
               else
                  state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_DONE;
            case (op_q)
               OP_ADD, OP_SUB: begin
                  wr_d = sum[WIDTH-1:0];
                  wc_d = sum[WIDTH];
                  wv_d = (a_q[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
               end
               OP_AND:   wr_d = a_q & b_q;
               OP_OR:    wr_d = a_q | b_q;
               OP_XOR:   wr_d = a_q ^ b_q;
               OP_NOTA:  wr_d = ~a_q;
               OP_PASSB: wr_d = b_q;
               OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: wr_d = a_q;
               default: begin
                  wr_d   = a_q;
                  keep_d = 1'b1;
               end
            endcase
         end
         ST_SHIFT: begin
            // one trailing cycle at count zero before committing
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               wr_d  = step_val;
               wc_d  = step_c;
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            result_d = wr_q;
            if (!keep_q) begin
               c_d = wc_q;
               v_d = wv_q;
               z_d = (wr_q == '0);
               n_d = wr_q[WIDTH-1];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         cin_q    <= 1'b0;
         cnt_q    <= '0;
         wr_q     <= '0;
         wc_q     <= 1'b0;
         wv_q     <= 1'b0;
         keep_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         c_q      <= c_d;
         z_q      <= z_d;
         n_q      <= n_d;
         v_q      <= v_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cin_q    <= cin_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         wc_q     <= wc_d;
         wv_q     <= wv_d;
         keep_q   <= keep_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign cout = c_q;
   assign zout = z_q;
   assign nout = n_q;
   assign vout = v_q;
   assign y    = notOE ? {WIDTH{1'bz}} : result_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector table plus handshake/reset/output-enable sequences for alu_seq
module tb_alu_seq;

   logic        clock = 1'b0;
   logic        notReset;
   logic [15:0] a, b;
   logic [3:0]  op;
   logic        csel, ucin, start, notOE;
   logic        busy, done, cout, zout, nout, vout;
   wire  [15:0] y;

   int errors = 0;
   int checks = 0;

   alu_seq #(.WIDTH(16), .SHW(4)) dut (
      .clock    (clock),
      .notReset (notReset),
      .a        (a),
      .b        (b),
      .op       (op),
      .csel     (csel),
      .ucin     (ucin),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .notOE    (notOE),
      .y        (y),
      .cout     (cout),
      .zout     (zout),
      .nout     (nout),
      .vout     (vout)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        csel;
      logic        ucin;
      logic [15:0] ey;
      logic        ec;
      logic        ez;
      logic        en;
      logic        ev;
      int          elat;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
   task automatic run_op(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic cs, input logic uc, output int lat);
      op = o; a = av; b = bv; csel = cs; ucin = uc; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int ndone;
      int first_done;

      vecs[0]  = '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[1]  = '{4'd1,  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 2};
      vecs[2]  = '{4'd2,  16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 16'h3030, 1'b1, 1'b0, 1'b0, 1'b0, 2};
      vecs[3]  = '{4'd3,  16'h8000, 16'h0001, 1'b0, 1'b0, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0, 2};
      vecs[4]  = '{4'd4,  16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[5]  = '{4'd5,  16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b1, 1'b0, 1'b1, 1'b0, 2};
      vecs[6]  = '{4'd6,  16'h0000, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 2};
      vecs[7]  = '{4'd7,  16'h8001, 16'h0004, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 6};
      vecs[8]  = '{4'd7,  16'h8001, 16'h0031, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[9]  = '{4'd0,  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 2};
      vecs[10] = '{4'd8,  16'h8001, 16'h0001, 1'b0, 1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[11] = '{4'd9,  16'h8000, 16'h0003, 1'b0, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 5};
      vecs[12] = '{4'd10, 16'h8001, 16'h0001, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[13] = '{4'd11, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 4};
      vecs[14] = '{4'd1,  16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[15] = '{4'd13, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 3};
      vecs[16] = '{4'd12, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[17] = '{4'd10, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[18] = '{4'd14, 16'h5555, 16'h0000, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[19] = '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[20] = '{4'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 2};

      notReset = 1'b0; a = '0; b = '0; op = '0; csel = 1'b0; ucin = 1'b0;
      start = 1'b0; notOE = 1'b0;
      #1;
      check("reset_y", y, 16'h0000);
      check("reset_flags", {cout, zout, nout, vout}, 4'b0000);
      check("reset_busy_done", {busy, done}, 2'b00);
      @(negedge clock);
      @(negedge clock);
      notReset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 21; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].csel, vecs[i].ucin, lat);
         check($sformatf("v%0d_lat", i), lat, vecs[i].elat);
         check($sformatf("v%0d_y", i), y, vecs[i].ey);
         check($sformatf("v%0d_c", i), cout, vecs[i].ec);
         check($sformatf("v%0d_z", i), zout, vecs[i].ez);
         check($sformatf("v%0d_n", i), nout, vecs[i].en);
         check($sformatf("v%0d_v", i), vout, vecs[i].ev);
      end

      // start pulsed mid-shift must be dropped
      op = 4'd7; a = 16'h8001; b = 16'h0004; csel = 1'b0; ucin = 1'b0; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      check("shift_busy", busy, 1'b1);
      check("shift_y_prev", y, 16'h0001);
      check("shift_c_hold", cout, 1'b0);
      @(posedge clock);
      @(negedge clock);
      op = 4'd0; a = 16'h0001; b = 16'h0001; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      ndone = 0;
      first_done = -1;
      for (int i = 3; i <= 16; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (done) begin
            ndone++;
            if (first_done < 0) first_done = i;
         end
      end
      check("ignore_done_count", ndone, 1);
      check("ignore_done_lat", first_done, 6);
      check("ignore_y", y, 16'h0010);
      check("ignore_busy_idle", busy, 1'b0);

      // output enable off while flags still update
      notOE = 1'b1;
      run_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
      checks++;
      if (y === 16'h8000) begin
         errors++;
         $display("FAIL oe_hiz: got %0h expected high-Z", y);
      end
      check("oe_lat", lat, 2);
      check("oe_flags", {cout, zout, nout, vout}, 4'b0011);
      notOE = 1'b0;
      #1;
      check("oe_y_back", y, 16'h8000);
      @(negedge clock);

      // async reset in the middle of a long shift
      op = 4'd7; a = 16'hFFFF; b = 16'h000F; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #2;
      notReset = 1'b0;
      #1;
      check("rst_mid_y", y, 16'h0000);
      check("rst_mid_flags", {cout, zout, nout, vout}, 4'b0000);
      check("rst_mid_busy_done", {busy, done}, 2'b00);
      @(negedge clock);
      notReset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (done) ndone++;
      end
      check("rst_no_done", ndone, 0);
      run_op(4'd0, 16'h0001, 16'h0002, 1'b1, 1'b1, lat);
      check("post_rst_lat", lat, 2);
      check("post_rst_y", y, 16'h0003);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
